// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

  localparam int PAT_W_DEF = 5;
  localparam int CNT_W_DEF = 8;
  localparam logic [4:0] DEFAULT_PAT_DEF = 5'b10010;

  // Map a requested pattern length onto the legal range 1..max_len.
  function automatic int clamp_len(input int len, input int max_len);
    if (len < 1) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all ones.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o,
  output logic             sat_o
);

  logic [CNT_W-1:0] count_q;

  assign sat_o   = &count_q;
  assign count_o = count_q;

  // Clear beats increment; increment stops once the counter is all ones.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_q <= '0;
    end else if (inc_i && !sat_o) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Run-time loadable serial pattern detector with Mealy/Moore match outputs
// and a saturating match counter.
//
// Stream handshake: en is a valid-only qualifier (no ready). A bit on j is
// consumed on every rising edge where en=1 and neither rst nor pat_ld is high;
// with en=0 the history holds and no match can be reported.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W       = PAT_W_DEF,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(DEFAULT_PAT_DEF),
  parameter int               CNT_W       = CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         j,
  input  logic                         ovl,
  input  logic                         pat_ld,
  input  logic [PAT_W-1:0]             pat_in,
  input  logic [$clog2(PAT_W+1)-1:0]   len_in,
  input  logic                         cnt_clr,
  output logic                         w,
  output logic                         w_reg,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         cnt_sat
);

  localparam int LEN_W = $clog2(PAT_W+1);

  // Only the newest PAT_W-1 history bits can ever take part in a compare
  // (the incoming j supplies the last pattern bit), so older bits are not kept.
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [PAT_W-2:0] hist_q;
  logic [LEN_W-1:0] fill_q;
  logic             w_reg_q;

  logic [PAT_W-1:0] cand;
  logic [PAT_W-1:0] mask;
  logic             fill_ok;
  logic             bits_eq;
  logic             match_now;
  logic [LEN_W-1:0] len_d;

  assign len_d = LEN_W'(clamp_len(int'(len_in), PAT_W));

  // Compare the newest len_q bits (history plus the bit on j) against the pattern.
  always_comb begin
    cand      = {hist_q, j};
    mask      = ~({PAT_W{1'b1}} << len_q);
    fill_ok   = (fill_q >= (len_q - LEN_W'(1)));
    bits_eq   = (((cand ^ pat_q) & mask) == '0);
    match_now = en & ~rst & ~pat_ld & fill_ok & bits_eq;
  end

  assign w     = match_now;
  assign w_reg = w_reg_q;

  // Pattern/length registers, shift history, valid-bit count and Moore output.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= DEFAULT_PAT;
      len_q   <= LEN_W'(PAT_W);
      hist_q  <= '0;
      fill_q  <= '0;
      w_reg_q <= 1'b0;
    end else begin
      w_reg_q <= match_now;
      if (pat_ld) begin
        // A new pattern invalidates the history; j in this cycle is dropped.
        pat_q  <= pat_in;
        len_q  <= len_d;
        fill_q <= '0;
      end else if (en) begin
        hist_q <= cand[PAT_W-2:0];
        if (match_now && !ovl) begin
          // Non-overlapping: the next match needs a full set of fresh bits.
          fill_q <= '0;
        end else if (fill_q != LEN_W'(PAT_W)) begin
          fill_q <= fill_q + LEN_W'(1);
        end
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i   (clk),
    .rst_i   (rst),
    .inc_i   (match_now),
    .clr_i   (cnt_clr),
    .count_o (match_cnt),
    .sat_o   (cnt_sat)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus a randomized run,
// all checked against a bit-queue reference model.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       j = 1'b0;
  logic       ovl = 1'b1;
  logic       pat_ld = 1'b0;
  logic [4:0] pat_in = 5'd0;
  logic [2:0] len_in = 3'd0;
  logic       cnt_clr = 1'b0;
  logic       w;
  logic       w_reg;
  logic [2:0] match_cnt;
  logic       cnt_sat;

  int checks = 0;
  int failures = 0;

  // Reference model: valid bits received since the last history discard,
  // oldest first, plus the active pattern and its length.
  logic       mbits[$];
  logic [4:0] mpat = 5'b10010;
  int         mlen = 5;
  int         exp_cnt = 0;

  // Per-cycle observed/expected values filled in by drive().
  logic       obs_w, exp_w, obs_wr, exp_wr, obs_sat;
  logic [2:0] obs_cnt;

  seq_detector_param #(
    .PAT_W       (5),
    .DEFAULT_PAT (5'b10010),
    .CNT_W       (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .j         (j),
    .ovl       (ovl),
    .pat_ld    (pat_ld),
    .pat_in    (pat_in),
    .len_in    (len_in),
    .cnt_clr   (cnt_clr),
    .w         (w),
    .w_reg     (w_reg),
    .match_cnt (match_cnt),
    .cnt_sat   (cnt_sat)
  );

  always #5 clk = ~clk;

  // A match exists when the newest mlen valid bits, read newest-first,
  // equal pattern bits 0,1,2,... (bit 0 is the last one received).
  function automatic logic model_match(input logic en_v, input logic j_v,
                                       input logic ld_v, input logic rst_v);
    int   n;
    logic b;
    if (!en_v || ld_v || rst_v) return 1'b0;
    n = mbits.size();
    if (n + 1 < mlen) return 1'b0;
    for (int k = 0; k < mlen; k++) begin
      b = (k == 0) ? j_v : mbits[n - k];
      if (b !== mpat[k[2:0]]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One clock of stimulus: drive after negedge, sample w before the edge,
  // advance the model on the edge, sample registered outputs after it.
  task automatic drive(input logic en_v, input logic j_v, input logic ovl_v,
                       input logic ld_v, input logic clr_v, input logic rst_v,
                       input logic [4:0] pin_v, input logic [2:0] lin_v);
    @(negedge clk);
    en = en_v; j = j_v; ovl = ovl_v; pat_ld = ld_v; cnt_clr = clr_v;
    rst = rst_v; pat_in = pin_v; len_in = lin_v;
    #1;
    obs_w = w;
    exp_w = model_match(en_v, j_v, ld_v, rst_v);
    @(posedge clk);
    #1;
    if (rst_v) begin
      mbits.delete();
      mpat = 5'b10010;
      mlen = 5;
      exp_cnt = 0;
    end else begin
      if (clr_v) exp_cnt = 0;
      else if (exp_w && exp_cnt < 7) exp_cnt++;
      if (ld_v) begin
        mpat = pin_v;
        mlen = (lin_v == 3'd0) ? 1 : ((lin_v > 3'd5) ? 5 : int'(lin_v));
        mbits.delete();
      end else if (en_v) begin
        if (exp_w && !ovl_v) begin
          mbits.delete();
        end else begin
          mbits.push_back(j_v);
          if (mbits.size() > 5) void'(mbits.pop_front());
        end
      end
    end
    exp_wr  = rst_v ? 1'b0 : exp_w;
    obs_wr  = w_reg;
    obs_cnt = match_cnt;
    obs_sat = cnt_sat;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 3'd0);
  endtask

  // Feed n bits (bits[n-1] first) with en=1; collect w / w_reg per bit index.
  task automatic run_stream(input logic [15:0] bits, input int n, input logic ovl_v,
                            output logic [15:0] w_o, output logic [15:0] w_e,
                            output logic [15:0] wr_o, output logic [15:0] wr_e);
    w_o = '0; w_e = '0; wr_o = '0; wr_e = '0;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, bits[4'(n - 1 - i)], ovl_v, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0);
      w_o[i[3:0]] = obs_w;  w_e[i[3:0]] = exp_w;
      wr_o[i[3:0]] = obs_wr; wr_e[i[3:0]] = exp_wr;
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, c[0], 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 3'd0);
      checks++;
      if (obs_w !== 1'b0) begin failures++; $display("FAIL reset_w actual=%b required=0", obs_w); end
    end
    checks++;
    if (obs_wr !== 1'b0) begin failures++; $display("FAIL reset_w_reg actual=%b required=0", obs_wr); end
    checks++;
    if (obs_cnt !== 3'd0) begin failures++; $display("FAIL reset_cnt actual=%0d required=0", obs_cnt); end
    checks++;
    if (obs_sat !== 1'b0) begin failures++; $display("FAIL reset_sat actual=%b required=0", obs_sat); end
  endtask

  task automatic test_overlap(input logic ovl_v, input logic [15:0] want, input int want_cnt);
    logic [15:0] w_o, w_e, wr_o, wr_e;
    do_reset();
    run_stream(16'b10010010, 8, ovl_v, w_o, w_e, wr_o, wr_e);
    checks++;
    if (w_o !== want) begin failures++; $display("FAIL stream_w ovl=%b actual=%h required=%h", ovl_v, w_o, want); end
    checks++;
    if (w_e !== want) begin failures++; $display("FAIL model_w ovl=%b actual=%h required=%h", ovl_v, w_e, want); end
    checks++;
    if (wr_o !== wr_e) begin failures++; $display("FAIL stream_w_reg ovl=%b actual=%h required=%h", ovl_v, wr_o, wr_e); end
    checks++;
    if (obs_cnt !== 3'(want_cnt)) begin failures++; $display("FAIL stream_cnt ovl=%b actual=%0d required=%0d", ovl_v, obs_cnt, want_cnt); end
  endtask

  task automatic test_partial_and_gaps();
    logic [15:0] w_o, w_e, wr_o, wr_e;
    logic [6:0]  en_s, j_s;
    do_reset();
    run_stream(16'b0010, 4, 1'b1, w_o, w_e, wr_o, wr_e);
    checks++;
    if (w_o !== 16'h0000) begin failures++; $display("FAIL partial_w actual=%h required=0000", w_o); end
    do_reset();
    // cycle c uses bit c; gaps at cycles 1 and 4 carry misleading j values
    en_s = 7'b1101101;
    j_s  = 7'b0110001;
    w_o = '0; w_e = '0;
    for (int c = 0; c < 7; c++) begin
      drive(en_s[c[2:0]], j_s[c[2:0]], 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0);
      w_o[c[3:0]] = obs_w; w_e[c[3:0]] = exp_w;
      checks++;
      if (obs_wr !== exp_wr) begin failures++; $display("FAIL gap_w_reg cycle=%0d actual=%b required=%b", c, obs_wr, exp_wr); end
    end
    checks++;
    if (w_o !== 16'h0040) begin failures++; $display("FAIL gap_w actual=%h required=0040", w_o); end
    checks++;
    if (w_e !== 16'h0040) begin failures++; $display("FAIL gap_model actual=%h required=0040", w_e); end
  endtask

  task automatic test_load();
    logic [15:0] w_o, w_e, wr_o, wr_e;
    do_reset();
    run_stream(16'b10, 2, 1'b1, w_o, w_e, wr_o, wr_e);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00101, 3'd3);
    checks++;
    if (obs_w !== 1'b0) begin failures++; $display("FAIL load_cycle_w actual=%b required=0", obs_w); end
    run_stream(16'b10101, 5, 1'b1, w_o, w_e, wr_o, wr_e);
    checks++;
    if (w_o !== 16'h0014) begin failures++; $display("FAIL load101_w actual=%h required=0014", w_o); end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b10110, 3'd7);
    run_stream(16'b10110, 5, 1'b1, w_o, w_e, wr_o, wr_e);
    checks++;
    if (w_o !== 16'h0010) begin failures++; $display("FAIL clamp_len_w actual=%h required=0010", w_o); end
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00001, 3'd0);
    run_stream(16'b10110, 5, 1'b1, w_o, w_e, wr_o, wr_e);
    checks++;
    if (w_o !== 16'h000D) begin failures++; $display("FAIL len1_w actual=%h required=000d", w_o); end
    checks++;
    if (obs_cnt !== 3'd6) begin failures++; $display("FAIL load_cnt actual=%0d required=6", obs_cnt); end
  endtask

  task automatic test_counter();
    logic [15:0] w_o, w_e, wr_o, wr_e;
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00001, 3'd1);
    run_stream(16'h01FF, 9, 1'b1, w_o, w_e, wr_o, wr_e);
    checks++;
    if (obs_cnt !== 3'd7) begin failures++; $display("FAIL sat_cnt actual=%0d required=7", obs_cnt); end
    checks++;
    if (obs_sat !== 1'b1) begin failures++; $display("FAIL sat_flag actual=%b required=1", obs_sat); end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 3'd0);
    checks++;
    if (obs_w !== 1'b1) begin failures++; $display("FAIL clr_match_w actual=%b required=1", obs_w); end
    checks++;
    if (obs_cnt !== 3'd0 || obs_sat !== 1'b0) begin
      failures++; $display("FAIL clr_wins actual=%0d/%b required=0/0", obs_cnt, obs_sat);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0);
    checks++;
    if (obs_cnt !== 3'd1) begin failures++; $display("FAIL cnt_after_clr actual=%0d required=1", obs_cnt); end
  endtask

  task automatic test_mid_reset();
    logic [15:0] w_o, w_e, wr_o, wr_e;
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00101, 3'd3);
    run_stream(16'b101, 3, 1'b1, w_o, w_e, wr_o, wr_e);
    run_stream(16'b1001, 4, 1'b1, w_o, w_e, wr_o, wr_e);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 3'd0);
    checks++;
    if (obs_w !== 1'b0) begin failures++; $display("FAIL midrst_w actual=%b required=0", obs_w); end
    checks++;
    if (obs_cnt !== 3'd0) begin failures++; $display("FAIL midrst_cnt actual=%0d required=0", obs_cnt); end
    run_stream(16'b0, 1, 1'b1, w_o, w_e, wr_o, wr_e);
    checks++;
    if (w_o !== 16'h0000) begin failures++; $display("FAIL midrst_next_w actual=%h required=0000", w_o); end
    run_stream(16'b10010, 5, 1'b1, w_o, w_e, wr_o, wr_e);
    checks++;
    if (w_o !== 16'h0010) begin failures++; $display("FAIL midrst_default_pat actual=%h required=0010", w_o); end
  endtask

  task automatic test_random();
    logic       en_v, j_v, ovl_v, ld_v, clr_v, rst_v;
    logic [4:0] pin_v;
    logic [2:0] lin_v;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst_v = ($urandom_range(0, 99) == 0);
      ld_v  = ($urandom_range(0, 24) == 0);
      clr_v = ($urandom_range(0, 29) == 0);
      en_v  = ($urandom_range(0, 3) != 0);
      j_v   = 1'($urandom_range(0, 1));
      ovl_v = 1'($urandom_range(0, 1));
      pin_v = 5'($urandom_range(0, 31));
      lin_v = 3'($urandom_range(0, 7));
      drive(en_v, j_v, ovl_v, ld_v, clr_v, rst_v, pin_v, lin_v);
      checks++;
      if (obs_w !== exp_w) begin failures++; $display("FAIL rand_w cycle=%0d actual=%b required=%b", c, obs_w, exp_w); end
      checks++;
      if (obs_wr !== exp_wr) begin failures++; $display("FAIL rand_w_reg cycle=%0d actual=%b required=%b", c, obs_wr, exp_wr); end
      checks++;
      if (obs_cnt !== 3'(exp_cnt)) begin failures++; $display("FAIL rand_cnt cycle=%0d actual=%0d required=%0d", c, obs_cnt, exp_cnt); end
      checks++;
      if (obs_sat !== (exp_cnt == 7)) begin failures++; $display("FAIL rand_sat cycle=%0d actual=%b required=%b", c, obs_sat, exp_cnt == 7); end
    end
  endtask

  initial begin
    test_reset();
    test_overlap(1'b1, 16'h0090, 2);
    test_overlap(1'b0, 16'h0010, 1);
    test_partial_and_gaps();
    test_load();
    test_counter();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
